// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types and constants: the {pc, inst} entry, reset PC and the NOP
// driven on an empty queue.
package fetch_queue_pkg;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam logic [PC_W-1:0]   RESET_PC = 32'h1C00_0000;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0340_0000;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: IF/ID stall/flush, instruction-memory request/response and IF/ID output.
// master = fetch_queue side, slave = pipeline/memory side.
interface fetch_queue_if;
   import fetch_queue_pkg::*;

   logic              stall;
   logic              flush;
   logic [PC_W-1:0]   redirect_pc;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [PC_W-1:0]   imem_req_pc;
   logic              imem_resp_valid;
   logic [INST_W-1:0] imem_resp_inst;
   logic              out_valid;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;

   modport master (
      input  stall, flush, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_inst,
      output imem_req_valid, imem_req_pc, out_valid, out_pc, out_inst
   );
   modport slave (
      output stall, flush, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_inst,
      input  imem_req_valid, imem_req_pc, out_valid, out_pc, out_inst
   );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with push/pop/clear and an occupancy count; DEPTH must be a power of 2.
// Used both for fetched entries and for the PC tags of in-flight requests.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  T              i_wdata,
   input  logic          i_pop,
   input  logic          i_clear,
   output T              o_rdata,
   output logic [CW-1:0] o_count
);
   T                r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + AW'(1);
         if (i_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, in-order response FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PC_W-1:0] r_pc;
   logic [CW-1:0]   r_discard;

   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_inflight;
   logic [CW:0]     w_occupancy;
   logic [PC_W-1:0] w_resp_pc;
   fetch_entry_t    w_head;
   fetch_entry_t    w_resp_ent;
   fetch_entry_t    w_out_ent;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_resp_fire;
   logic            w_drop;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_vld;
   logic            w_byp;
   logic            w_out_vld;

   // Credits cover both buffered and in-flight entries, so the FIFO can never overflow.
   assign w_occupancy = {1'b0, w_count} + {1'b0, w_inflight};
   assign w_req_valid = !rst && !bus.flush && (w_occupancy < (CW+1)'(DEPTH));
   assign w_req_fire  = w_req_valid && bus.imem_req_ready;
   assign w_resp_fire = bus.imem_resp_valid && (w_inflight != '0);
   assign w_drop      = w_resp_fire && ((r_discard != '0) || bus.flush);
   assign w_fifo_vld  = (w_count != '0);

`ifdef FETCH_BYPASS_EN
   assign w_byp = !w_fifo_vld && (r_discard == '0) && !bus.flush && w_resp_fire;
`else
   assign w_byp = 1'b0;
`endif

   assign w_push     = w_resp_fire && !w_drop && !(w_byp && !bus.stall);
   assign w_pop      = w_fifo_vld && !bus.stall && !bus.flush;
   assign w_resp_ent = '{pc: w_resp_pc, inst: bus.imem_resp_inst};
   assign w_out_ent  = w_fifo_vld ? w_head : w_resp_ent;
   assign w_out_vld  = w_fifo_vld || w_byp;

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_pc    = r_pc;
   assign bus.out_valid      = w_out_vld;
   assign bus.out_pc         = w_out_vld ? w_out_ent.pc : '0;
   assign bus.out_inst       = w_out_vld ? w_out_ent.inst : NOP_INST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               r_pc <= RESET_PC;
      else if (bus.flush)    r_pc <= bus.redirect_pc;
      else if (w_req_fire)   r_pc <= r_pc + PC_W'(4);
   end

   // Everything still in flight at a flush belongs to the old path and must be dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_discard <= '0;
      else if (bus.flush)                         r_discard <= w_inflight - CW'(w_resp_fire);
      else if (w_resp_fire && r_discard != '0)    r_discard <= r_discard - CW'(1);
   end

   fetch_fifo #(.DEPTH(DEPTH), .T(logic [PC_W-1:0])) u_tag (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_req_fire),
      .i_wdata (r_pc),
      .i_pop   (w_resp_fire),
      .i_clear (1'b0),
      .o_rdata (w_resp_pc),
      .o_count (w_inflight)
   );

   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_resp_ent),
      .i_pop   (w_pop),
      .i_clear (bus.flush),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   a_credit: assert property (@(posedge clk) disable iff (rst) w_occupancy <= (CW+1)'(DEPTH));
endmodule
